// File: rtl/decode_stage.sv
// Decode stage: register file with write-through bypass, main/ALU decoders,
// immediate extender and the ID/EX pipeline register feeding execute.
module decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic [31:0]     instr_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] pc_plus4_d,
  input  logic            flush_e,
  input  logic            reg_write_w,
  input  logic [4:0]      rd_w,
  input  logic [XLEN-1:0] result_w,
  output logic [4:0]      rs1_d,
  output logic [4:0]      rs2_d,
  output logic            reg_write_e,
  output logic [1:0]      result_src_e,
  output logic            mem_write_e,
  output logic            jump_e,
  output logic            branch_e,
  output logic [2:0]      alu_control_e,
  output logic            alu_src_e,
  output logic [XLEN-1:0] rd1_e,
  output logic [XLEN-1:0] rd2_e,
  output logic [XLEN-1:0] imm_ext_e,
  output logic [4:0]      rs1_e,
  output logic [4:0]      rs2_e,
  output logic [4:0]      rd_e,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] pc_plus4_e
);

  localparam int unsigned RW = 5;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          funct7b5;
  logic [RW-1:0] rd_dec;

  assign opcode   = instr_d[6:0];
  assign funct3   = instr_d[14:12];
  assign funct7b5 = instr_d[30];
  assign rd_dec   = instr_d[11:7];
  assign rs1_d    = instr_d[19:15];
  assign rs2_d    = instr_d[24:20];

  // Register file storage; x0 is never written so it stays zero
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic            wb_en;

  assign wb_en = reg_write_w && (rd_w != RW'(0));

  // Next register-file contents from the writeback port
  always_comb begin
    regs_d = regs_q;
    if (wb_en) begin
      regs_d[rd_w] = result_w;
    end
  end

  // Register-file state, cleared by reset
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Combinational reads with x0 forced to zero and same-cycle writeback bypass
  logic [XLEN-1:0] rd1_c;
  logic [XLEN-1:0] rd2_c;

  always_comb begin
    rd1_c = '0;
    rd2_c = '0;
    if (rs1_d != RW'(0)) begin
      rd1_c = (wb_en && (rd_w == rs1_d)) ? result_w : regs_q[rs1_d];
    end
    if (rs2_d != RW'(0)) begin
      rd2_c = (wb_en && (rd_w == rs2_d)) ? result_w : regs_q[rs2_d];
    end
  end

  // Main decoder; unrecognised opcodes produce an all-zero bubble
  logic       reg_write_c;
  logic [1:0] imm_src_c;
  logic       alu_src_c;
  logic       mem_write_c;
  logic [1:0] result_src_c;
  logic       branch_c;
  logic [1:0] alu_op_c;
  logic       jump_c;

  always_comb begin
    reg_write_c  = 1'b0;
    imm_src_c    = 2'b00;
    alu_src_c    = 1'b0;
    mem_write_c  = 1'b0;
    result_src_c = 2'b00;
    branch_c     = 1'b0;
    alu_op_c     = 2'b00;
    jump_c       = 1'b0;
    unique case (opcode)
      OP_LW: begin
        reg_write_c  = 1'b1;
        alu_src_c    = 1'b1;
        result_src_c = 2'b01;
      end
      OP_SW: begin
        imm_src_c   = 2'b01;
        alu_src_c   = 1'b1;
        mem_write_c = 1'b1;
      end
      OP_R: begin
        reg_write_c = 1'b1;
        alu_op_c    = 2'b10;
      end
      OP_BEQ: begin
        imm_src_c = 2'b10;
        branch_c  = 1'b1;
        alu_op_c  = 2'b01;
      end
      OP_IALU: begin
        reg_write_c = 1'b1;
        alu_src_c   = 1'b1;
        alu_op_c    = 2'b10;
      end
      OP_JAL: begin
        reg_write_c  = 1'b1;
        imm_src_c    = 2'b11;
        result_src_c = 2'b10;
        jump_c       = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // ALU decoder; subtract from funct3=000 only for R-type with funct7[5] set
  logic [2:0] alu_control_c;

  always_comb begin
    alu_control_c = ALU_ADD;
    unique case (alu_op_c)
      2'b01: alu_control_c = ALU_SUB;
      2'b10: begin
        unique case (funct3)
          3'b000:  alu_control_c = (opcode[5] && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_c = ALU_SLT;
          3'b110:  alu_control_c = ALU_OR;
          3'b111:  alu_control_c = ALU_AND;
          default: alu_control_c = ALU_ADD;
        endcase
      end
      default: alu_control_c = ALU_ADD;
    endcase
  end

  // Immediate extender selected by instruction format
  logic [XLEN-1:0] imm_ext_c;

  always_comb begin
    imm_ext_c = '0;
    unique case (imm_src_c)
      2'b00: imm_ext_c = XLEN'({{20{instr_d[31]}}, instr_d[31:20]});
      2'b01: imm_ext_c = XLEN'({{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]});
      2'b10: imm_ext_c = XLEN'({{19{instr_d[31]}}, instr_d[31], instr_d[7],
                                instr_d[30:25], instr_d[11:8], 1'b0});
      2'b11: imm_ext_c = XLEN'({{11{instr_d[31]}}, instr_d[31], instr_d[19:12],
                                instr_d[20], instr_d[30:21], 1'b0});
      default: imm_ext_c = '0;
    endcase
  end

  // ID/EX next state: decoded values, or an all-zero bubble on flush
  logic            reg_write_q,   reg_write_d;
  logic [1:0]      result_src_q,  result_src_d;
  logic            mem_write_q,   mem_write_d;
  logic            jump_q,        jump_d;
  logic            branch_q,      branch_d;
  logic [2:0]      alu_control_q, alu_control_d;
  logic            alu_src_q,     alu_src_d;
  logic [XLEN-1:0] rd1_q,         rd1_d;
  logic [XLEN-1:0] rd2_q,         rd2_d;
  logic [XLEN-1:0] imm_ext_q,     imm_ext_d;
  logic [RW-1:0]   rs1_q,         rs1_nx_d;
  logic [RW-1:0]   rs2_q,         rs2_nx_d;
  logic [RW-1:0]   rd_q,          rd_d;
  logic [XLEN-1:0] pc_q,          pc_nx_d;
  logic [XLEN-1:0] pc_plus4_q,    pc_plus4_nx_d;

  always_comb begin
    reg_write_d   = reg_write_c;
    result_src_d  = result_src_c;
    mem_write_d   = mem_write_c;
    jump_d        = jump_c;
    branch_d      = branch_c;
    alu_control_d = alu_control_c;
    alu_src_d     = alu_src_c;
    rd1_d         = rd1_c;
    rd2_d         = rd2_c;
    imm_ext_d     = imm_ext_c;
    rs1_nx_d      = rs1_d;
    rs2_nx_d      = rs2_d;
    rd_d          = rd_dec;
    pc_nx_d       = pc_d;
    pc_plus4_nx_d = pc_plus4_d;
    if (flush_e) begin
      reg_write_d   = 1'b0;
      result_src_d  = 2'b00;
      mem_write_d   = 1'b0;
      jump_d        = 1'b0;
      branch_d      = 1'b0;
      alu_control_d = 3'b000;
      alu_src_d     = 1'b0;
      rd1_d         = '0;
      rd2_d         = '0;
      imm_ext_d     = '0;
      rs1_nx_d      = '0;
      rs2_nx_d      = '0;
      rd_d          = '0;
      pc_nx_d       = '0;
      pc_plus4_nx_d = '0;
    end
  end

  // ID/EX pipeline register, loads every cycle
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      reg_write_q   <= 1'b0;
      result_src_q  <= 2'b00;
      mem_write_q   <= 1'b0;
      jump_q        <= 1'b0;
      branch_q      <= 1'b0;
      alu_control_q <= 3'b000;
      alu_src_q     <= 1'b0;
      rd1_q         <= '0;
      rd2_q         <= '0;
      imm_ext_q     <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      pc_q          <= '0;
      pc_plus4_q    <= '0;
    end else begin
      reg_write_q   <= reg_write_d;
      result_src_q  <= result_src_d;
      mem_write_q   <= mem_write_d;
      jump_q        <= jump_d;
      branch_q      <= branch_d;
      alu_control_q <= alu_control_d;
      alu_src_q     <= alu_src_d;
      rd1_q         <= rd1_d;
      rd2_q         <= rd2_d;
      imm_ext_q     <= imm_ext_d;
      rs1_q         <= rs1_nx_d;
      rs2_q         <= rs2_nx_d;
      rd_q          <= rd_d;
      pc_q          <= pc_nx_d;
      pc_plus4_q    <= pc_plus4_nx_d;
    end
  end

  assign reg_write_e   = reg_write_q;
  assign result_src_e  = result_src_q;
  assign mem_write_e   = mem_write_q;
  assign jump_e        = jump_q;
  assign branch_e      = branch_q;
  assign alu_control_e = alu_control_q;
  assign alu_src_e     = alu_src_q;
  assign rd1_e         = rd1_q;
  assign rd2_e         = rd2_q;
  assign imm_ext_e     = imm_ext_q;
  assign rs1_e         = rs1_q;
  assign rs2_e         = rs2_q;
  assign rd_e          = rd_q;
  assign pc_e          = pc_q;
  assign pc_plus4_e    = pc_plus4_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus pushes the expected ID/EX
// contents for the next edge, a monitor pops and compares after each edge.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic        flush_e, reg_write_w;
  logic [4:0]  rd_w;
  logic [31:0] result_w;
  logic [4:0]  rs1_d, rs2_d;
  logic        reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e;
  logic [1:0]  result_src_e;
  logic [2:0]  alu_control_e;
  logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;

  decode_stage dut (
    .clk(clk), .arst_n(arst_n), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .flush_e(flush_e), .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .reg_write_e(reg_write_e), .result_src_e(result_src_e),
    .mem_write_e(mem_write_e), .jump_e(jump_e), .branch_e(branch_e),
    .alu_control_e(alu_control_e), .alu_src_e(alu_src_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
    .imm_ext_e(imm_ext_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .pc_e(pc_e),
    .pc_plus4_e(pc_plus4_e)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        reg_write, mem_write, jump, branch, alu_src;
    logic [1:0]  result_src;
    logic [2:0]  alu_control;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
    bit          chk_imm;
    bit          chk_alu;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] ref_regs [32];
  int          errors = 0;
  int          checks = 0;

  // ALU operation meaning for register/immediate arithmetic by funct3
  function automatic logic [2:0] arith_op(input logic [2:0] f3, input bit sub_ok);
    case (f3)
      3'b000:  return sub_ok ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [31:0] read_ref(input logic [4:0] r, input logic we,
                                           input logic [4:0] wr, input logic [31:0] wv);
    if (r == 5'd0) return 32'd0;
    if (we && wr == r) return wv;
    return ref_regs[r];
  endfunction

  // Reference decode: instruction class semantics with signed immediates
  task automatic ref_decode(input logic [31:0] ins, inout exp_t e);
    logic [11:0] i12, s12;
    logic [12:0] b13;
    logic [20:0] j21;
    i12 = ins[31:20];
    s12 = {ins[31:25], ins[11:7]};
    b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    case (ins[6:0])
      7'b0000011: begin
        e.reg_write = 1; e.result_src = 2'b01; e.alu_src = 1; e.alu_control = 3'b000;
        e.imm = 32'($signed(i12)); e.chk_imm = 1;
      end
      7'b0100011: begin
        e.mem_write = 1; e.alu_src = 1; e.alu_control = 3'b000;
        e.imm = 32'($signed(s12)); e.chk_imm = 1;
      end
      7'b0110011: begin
        e.reg_write = 1; e.alu_control = arith_op(ins[14:12], ins[30]);
      end
      7'b1100011: begin
        e.branch = 1; e.alu_control = 3'b001;
        e.imm = 32'($signed(b13)); e.chk_imm = 1;
      end
      7'b0010011: begin
        e.reg_write = 1; e.alu_src = 1; e.alu_control = arith_op(ins[14:12], 1'b0);
        e.imm = 32'($signed(i12)); e.chk_imm = 1;
      end
      7'b1101111: begin
        e.reg_write = 1; e.result_src = 2'b10; e.jump = 1; e.chk_alu = 0;
        e.imm = 32'($signed(j21)); e.chk_imm = 1;
      end
      default: begin
      end
    endcase
  endtask

  // One decode cycle: drive inputs after negedge and queue the expected ID/EX
  task automatic step(input string tag, input logic [31:0] ins, input logic fl,
                      input logic we, input logic [4:0] wr, input logic [31:0] wv,
                      input logic rst);
    exp_t        e;
    logic [31:0] pc;
    @(negedge clk);
    pc = $urandom & 32'hFFFF_FFFC;
    arst_n = ~rst; instr_d = ins; pc_d = pc; pc_plus4_d = pc + 32'd4;
    flush_e = fl; reg_write_w = we; rd_w = wr; result_w = wv;
    e.tag = tag;
    e.reg_write = 0; e.mem_write = 0; e.jump = 0; e.branch = 0; e.alu_src = 0;
    e.result_src = 0; e.alu_control = 0;
    e.rd1 = 0; e.rd2 = 0; e.imm = 0; e.pc = 0; e.pc4 = 0; e.rs1 = 0; e.rs2 = 0; e.rd = 0;
    e.chk_imm = 1; e.chk_alu = 1;
    if (rst) begin
      for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
    end else begin
      if (!fl) begin
        e.chk_imm = 0;
        ref_decode(ins, e);
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
        e.rd1 = read_ref(ins[19:15], we, wr, wv);
        e.rd2 = read_ref(ins[24:20], we, wr, wv);
        e.pc = pc; e.pc4 = pc + 32'd4;
      end
      if (we && wr != 5'd0) ref_regs[wr] = wv;
    end
    sb_q.push_back(e);
  endtask

  task automatic cmp(input string tag, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h", tag, fld, act, exp);
    end
  endtask

  // Monitor: ID/EX is presented every cycle; compare just after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        cmp(e.tag, "reg_write_e",  32'(reg_write_e),  32'(e.reg_write));
        cmp(e.tag, "result_src_e", 32'(result_src_e), 32'(e.result_src));
        cmp(e.tag, "mem_write_e",  32'(mem_write_e),  32'(e.mem_write));
        cmp(e.tag, "jump_e",       32'(jump_e),       32'(e.jump));
        cmp(e.tag, "branch_e",     32'(branch_e),     32'(e.branch));
        if (e.chk_alu) begin
          cmp(e.tag, "alu_control_e", 32'(alu_control_e), 32'(e.alu_control));
          cmp(e.tag, "alu_src_e",     32'(alu_src_e),     32'(e.alu_src));
        end
        if (e.chk_imm) cmp(e.tag, "imm_ext_e", imm_ext_e, e.imm);
        cmp(e.tag, "rd1_e",      rd1_e,       e.rd1);
        cmp(e.tag, "rd2_e",      rd2_e,       e.rd2);
        cmp(e.tag, "rs1_e",      32'(rs1_e),  32'(e.rs1));
        cmp(e.tag, "rs2_e",      32'(rs2_e),  32'(e.rs2));
        cmp(e.tag, "rd_e",       32'(rd_e),   32'(e.rd));
        cmp(e.tag, "pc_e",       pc_e,        e.pc);
        cmp(e.tag, "pc_plus4_e", pc_plus4_e,  e.pc4);
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized traffic
  initial begin
    logic [6:0]  ops [8];
    logic [31:0] ins;
    logic [4:0]  wr;
    int          budget;
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011; ops[3] = 7'b1100011;
    ops[4] = 7'b0010011; ops[5] = 7'b1101111; ops[6] = 7'b1111111; ops[7] = 7'b0000000;
    arst_n = 1'b0; instr_d = 0; pc_d = 0; pc_plus4_d = 0; flush_e = 0;
    reg_write_w = 0; rd_w = 0; result_w = 0;
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;

    step("reset", 32'h0000_0333, 0, 0, 0, 0, 1);
    step("reset", 32'h0000_0333, 0, 0, 0, 0, 1);
    for (int i = 1; i < 32; i++)
      step("prefill", 32'h0000_0033, 0, 1, 5'(i), $urandom, 0);
    step("reset_mid", 32'h0020_8033, 0, 1, 5'd3, 32'h1111, 1);
    step("reset_mid", 32'h0020_8033, 0, 0, 0, 0, 1);
    step("reset_mid", 32'hFFC1_2083, 0, 0, 0, 0, 1);
    for (int i = 1; i < 32; i++)
      step("read_after_reset", {12'd0, 5'(i), 3'b000, 5'd1, 7'b0110011}, 0, 0, 0, 0, 0);

    step("write_x5", 32'h0000_0000, 0, 1, 5'd5, 32'hDEAD_BEEF, 0);
    step("add_x6_x5_x0", 32'h0002_8333, 0, 0, 0, 0, 0);
    step("write_x0", 32'h0000_0333, 0, 1, 5'd0, 32'h0000_1234, 0);
    step("read_x0", 32'h0000_0333, 0, 0, 0, 0, 0);
    step("bypass_x7", 32'h0003_8413, 0, 1, 5'd7, 32'h0000_0055, 0);
    step("lw_neg4", 32'hFFC1_2083, 0, 0, 0, 0, 0);
    step("beq_neg8", 32'hFE00_0CE3, 0, 0, 0, 0, 0);
    step("jal_2048", 32'h0010_00EF, 0, 0, 0, 0, 0);
    step("sw_flushed", 32'h0032_2423, 1, 0, 0, 0, 0);
    step("sw_after_flush", 32'h0032_2423, 0, 0, 0, 0, 0);
    step("sub", 32'h4020_8033, 0, 0, 0, 0, 0);
    step("slt", 32'h0020_A033, 0, 0, 0, 0, 0);
    step("or", 32'h0020_E033, 0, 0, 0, 0, 0);
    step("and", 32'h0020_F033, 0, 0, 0, 0, 0);
    step("unknown_op", 32'h0000_007F, 0, 0, 0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 7)];
      if (ins[6:0] == 7'b0000000 && $urandom_range(0, 1) == 0) ins = 32'd0;
      wr = ($urandom_range(0, 3) == 0) ? ins[19:15] : 5'($urandom_range(0, 31));
      step("random", ins, ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) != 0), wr,
           $urandom, ($urandom_range(0, 99) == 0));
    end
    step("drain", 32'd0, 0, 0, 0, 0, 0);

    budget = 20;
    while (sb_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
